mux_force_decoder: RTL and testbench



---
 rtl/mux_force_decoder.sv | 216 +++++++++++++++++++++
 tb/tb_mux_force_decoder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mux_force_decoder.sv
// -----------------------------------------------------------------------------
// mux_force_decoder
// Receive-side decoder for the forced-mux datapath. Upstream forces an all-ones
// word while its override select is active. This block strips those words and
// queues genuine data in a small FIFO. It also reports override activity:
// current run length, sustained-override state and total drop count.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   upstream word present
//   in_data      in   upstream word (mux output)
//   in_ready     out  block can accept a word (registered, !full)
//   out_valid    out  FIFO head valid
//   out_data     out  FIFO head data (holds last value when empty)
//   out_ready    in   downstream consumes head
//   force_active out  sustained override detected
//   force_run    out  consecutive forced-word count, saturating at 255
//   drop_cnt     out  forced words discarded since reset, saturating
// -----------------------------------------------------------------------------
module mux_force_decoder #(
    parameter int WIDTH        = 16,
    parameter int DEPTH        = 4,
    parameter int FORCE_THRESH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             force_active,
    output logic [7:0]       force_run,
    output logic [15:0]      drop_cnt
);

    localparam int         AW     = $clog2(DEPTH);
    localparam logic [7:0] THRESH = 8'(FORCE_THRESH);

    typedef enum logic [1:0] {
        ST_PASS    = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_FORCED  = 2'd2
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            sat_inc8 = v;
        end else begin
            sat_inc8 = v + 8'd1;
        end
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            sat_inc16 = v;
        end else begin
            sat_inc16 = v + 16'd1;
        end
    endfunction

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [7:0]       r_force_run;
    logic [15:0]      r_drop_cnt;
    logic             r_force_active;
    state_t           r_state;

    logic             w_accept;
    logic             w_is_forced;
    logic             w_push;
    logic             w_pop;
    logic [AW:0]      w_wr_ptr_nxt;
    logic [AW:0]      w_rd_ptr_nxt;
    logic             w_empty_nxt;
    logic             w_full_nxt;
    logic [WIDTH-1:0] w_head_nxt;
    logic [7:0]       w_run_nxt;
    logic [15:0]      w_drop_nxt;
    state_t           w_state_nxt;
    logic             w_force_active_nxt;

    // Handshake decode and word classification.
    always_comb begin
        w_accept    = in_valid & r_in_ready;
        w_is_forced = (in_data == {WIDTH{1'b1}});
        w_push      = w_accept & ~w_is_forced;
        w_pop       = r_out_valid & out_ready;
    end

    // Next FIFO pointers, flags and head word after this edge.
    always_comb begin
        if (w_push) begin
            w_wr_ptr_nxt = r_wr_ptr + {{AW{1'b0}}, 1'b1};
        end else begin
            w_wr_ptr_nxt = r_wr_ptr;
        end
        if (w_pop) begin
            w_rd_ptr_nxt = r_rd_ptr + {{AW{1'b0}}, 1'b1};
        end else begin
            w_rd_ptr_nxt = r_rd_ptr;
        end
        w_empty_nxt = (w_wr_ptr_nxt == w_rd_ptr_nxt);
        w_full_nxt  = (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]) &&
                      (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]);
        // The word being written this edge becomes the head when it lands in the
        // slot the read pointer will point at; bypass it so there is no bubble.
        if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
            w_head_nxt = in_data;
        end else begin
            w_head_nxt = r_mem[w_rd_ptr_nxt[AW-1:0]];
        end
    end

    // Run-length and drop counters, changing only on accepted words.
    always_comb begin
        w_run_nxt  = r_force_run;
        w_drop_nxt = r_drop_cnt;
        if (w_accept && w_is_forced) begin
            w_run_nxt  = sat_inc8(r_force_run);
            w_drop_nxt = sat_inc16(r_drop_cnt);
        end else if (w_accept) begin
            w_run_nxt  = 8'd0;
        end else begin
            w_run_nxt  = r_force_run;
        end
    end

    // Override state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_PASS;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Override next-state logic; stalled words never advance the state.
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            case (r_state)
                ST_PASS, ST_SUSPECT: begin
                    if (!w_is_forced) begin
                        w_state_nxt = ST_PASS;
                    end else if (w_run_nxt >= THRESH) begin
                        w_state_nxt = ST_FORCED;
                    end else begin
                        w_state_nxt = ST_SUSPECT;
                    end
                end
                ST_FORCED: begin
                    if (w_is_forced) begin
                        w_state_nxt = ST_FORCED;
                    end else begin
                        w_state_nxt = ST_PASS;
                    end
                end
                default: w_state_nxt = ST_PASS;
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Override output decode, registered below alongside the state.
    always_comb begin
        w_force_active_nxt = (w_state_nxt == ST_FORCED);
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= in_data;
        end
    end

    // Pointers, registered flags, head data and status counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_in_ready     <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_force_run    <= 8'd0;
            r_drop_cnt     <= 16'd0;
            r_force_active <= 1'b0;
        end else begin
            r_wr_ptr       <= w_wr_ptr_nxt;
            r_rd_ptr       <= w_rd_ptr_nxt;
            r_in_ready     <= ~w_full_nxt;
            r_out_valid    <= ~w_empty_nxt;
            if (!w_empty_nxt) begin
                r_out_data <= w_head_nxt;
            end
            r_force_run    <= w_run_nxt;
            r_drop_cnt     <= w_drop_nxt;
            r_force_active <= w_force_active_nxt;
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign force_active = r_force_active;
    assign force_run    = r_force_run;
    assign drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_mux_force_decoder.sv
module tb_mux_force_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready = 1'b0;
    logic        force_active;
    logic [7:0]  force_run;
    logic [15:0] drop_cnt;

    int tests = 0;
    int fails = 0;
    logic [15:0] exp_q[$];
    int          exp_drop = 0;

    mux_force_decoder #(.WIDTH(16), .DEPTH(4), .FORCE_THRESH(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .force_active(force_active),
        .force_run(force_run), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: a pop happens at the next posedge when out_valid & out_ready now.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $error("FAIL sb_extra: observed word %0h expected none", out_data);
            end else begin
                assert (out_data === exp_q[0]) else begin
                    fails++;
                    $error("FAIL sb_data: observed %0h expected %0h", out_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    // Present one word and hold it until accepted (bounded wait).
    task automatic send(input logic [15:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_accept", {31'd0, in_ready}, 32'd1);
        if (in_ready) begin
            if (d != 16'hFFFF) exp_q.push_back(d);
            else if (exp_drop < 65535) exp_drop++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        check("rst_force_active", {31'd0, force_active}, 32'd0);
        check("rst_drop", {16'd0, drop_cnt}, 32'd0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

        // Test 1: three data words, each visible one cycle after acceptance
        out_ready = 1'b1;
        send(16'h0001);
        check("t1_lat_valid0", {31'd0, out_valid}, 32'd1);
        check("t1_lat_data0", {16'd0, out_data}, 32'h0001);
        send(16'h1234);
        check("t1_lat_data1", {16'd0, out_data}, 32'h1234);
        send(16'hABCD);
        check("t1_lat_data2", {16'd0, out_data}, 32'hABCD);
        drain();
        check("t1_force_active", {31'd0, force_active}, 32'd0);
        check("t1_drop", {16'd0, drop_cnt}, 32'd0);

        // Test 2: forced run reaching threshold, then a data word
        send(16'hFFFF);
        check("t2_run1", {24'd0, force_run}, 32'd1);
        check("t2_active1", {31'd0, force_active}, 32'd0);
        send(16'hFFFF);
        check("t2_run2", {24'd0, force_run}, 32'd2);
        check("t2_active2", {31'd0, force_active}, 32'd0);
        send(16'hFFFF);
        check("t2_run3", {24'd0, force_run}, 32'd3);
        check("t2_active3", {31'd0, force_active}, 32'd1);
        check("t2_no_output", {31'd0, out_valid}, 32'd0);
        send(16'h0055);
        check("t2_run_clr", {24'd0, force_run}, 32'd0);
        check("t2_active_clr", {31'd0, force_active}, 32'd0);
        check("t2_drop", {16'd0, drop_cnt}, 32'd3);
        drain();

        // Test 3: fill FIFO under backpressure, fifth word held upstream
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(16'h0100 + 16'(i));
        check("t3_full_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1;
        in_data  = 16'h0104;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_stall_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(16'h0104);
        drain();

        // Test 4: steady push+pop at occupancy 2, pointers wrap
        out_ready = 1'b0;
        send(16'h4A00);
        send(16'h4A01);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h4B00 + 16'(i);
            @(negedge clk);
            check("t4_ready", {31'd0, in_ready}, 32'd1);
            check("t4_valid", {31'd0, out_valid}, 32'd1);
            exp_q.push_back(in_data);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("t4_occupancy", exp_q.size(), 32'd2);
        drain();

        // Test 5: 300 forced words, saturating run length
        for (int i = 0; i < 300; i++) send(16'hFFFF);
        check("t5_run_sat", {24'd0, force_run}, 32'd255);
        check("t5_drop", {16'd0, drop_cnt}, exp_drop);
        check("t5_drop_abs", {16'd0, drop_cnt}, 32'd303);
        check("t5_active", {31'd0, force_active}, 32'd1);
        check("t5_fifo_empty", {31'd0, out_valid}, 32'd0);
        send(16'h0066);
        drain();

        // Test 6: asynchronous reset with queued data and override active
        out_ready = 1'b0;
        send(16'h0C01);
        send(16'h0C02);
        send(16'h0C03);
        send(16'hFFFF);
        send(16'hFFFF);
        send(16'hFFFF);
        check("t6_pre_active", {31'd0, force_active}, 32'd1);
        check("t6_pre_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t6_rst_data", {16'd0, out_data}, 32'd0);
        check("t6_rst_ready", {31'd0, in_ready}, 32'd0);
        check("t6_rst_active", {31'd0, force_active}, 32'd0);
        check("t6_rst_run", {24'd0, force_run}, 32'd0);
        check("t6_rst_drop", {16'd0, drop_cnt}, 32'd0);
        #7 rst_n = 1'b1;
        @(posedge clk); #1;
        check("t6_ready_after", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        send(16'h0007);
        check("t6_data_out", {16'd0, out_data}, 32'h0007);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
